// File: rtl/mips_pkg.sv
// Shared definitions for the program loader: state encoding, UART command
// bytes and instruction-set constants.
package mips_pkg;

  localparam int INSTRUCTION_LENGTH = 32;
  localparam int PC_LENGTH          = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_RUN,
    ST_STEP,
    ST_STEP_PULSE,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'
  localparam logic [7:0] CMD_EXIT = 8'h45;  // 'E'
  localparam logic [7:0] ACK_DONE = 8'h44;  // 'D'

  localparam logic [31:0] HALT_INSTRUCTION = 32'hFC00_0000;

  function automatic logic is_halt(input logic [31:0] word);
    return word == HALT_INSTRUCTION;
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a byte stream (MSB first) into 32-bit words; word/word_ready are
// combinational views of the word completed by the current byte.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [1:0]  byte_count
);

  logic [31:0] shift;
  logic [1:0]  count;

  assign word       = {shift[23:0], byte_in};
  assign word_ready = byte_valid && (count == 2'd3);
  assign byte_count = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift <= '0;
      count <= '0;
    end else if (clear) begin
      shift <= '0;
      count <= '0;
    end else if (byte_valid) begin
      shift <= word;
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a program from the UART into instruction memory, then runs the
// pipeline continuously or one cycle per step command.
module program_loader #(
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int PC_LENGTH          = 32,
  parameter int MEM_WORDS          = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          halt_detected,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic                          wr_memory_instruction_enable,
  output logic [INSTRUCTION_LENGTH-1:0] instruction_to_write,
  output logic [PC_LENGTH-1:0]          address_to_write,
  output logic                          mips_enable,
  output logic                          pc_enable
);

  import mips_pkg::*;

  localparam logic [PC_LENGTH-1:0] LAST_ADDRESS = PC_LENGTH'((MEM_WORDS - 1) * 4);
  localparam logic [PC_LENGTH-1:0] WORD_BYTES   = PC_LENGTH'(4);

  state_t      state;
  state_t      state_next;
  logic        asm_clear;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic        asm_ready;
  logic [1:0]  asm_count;
  logic        write_last;
  logic        send_ack;

  assign asm_valid = rx_valid && (state == ST_LOAD);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_data),
    .word       (asm_word),
    .word_ready (asm_ready),
    .byte_count (asm_count)
  );

  assign write_last = is_halt(32'(instruction_to_write)) ||
                      (address_to_write == LAST_ADDRESS);
  assign send_ack   = (state == ST_DONE) && !tx_busy;

  always_comb begin
    state_next = state;
    asm_clear  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data)
            CMD_LOAD: begin
              state_next = ST_LOAD;
              asm_clear  = 1'b1;
            end
            CMD_CONT: state_next = ST_RUN;
            CMD_STEP: state_next = ST_STEP;
            default:  state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        if (asm_ready) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = write_last ? ST_IDLE : ST_LOAD;
      end
      ST_RUN: begin
        if (halt_detected) state_next = ST_DONE;
      end
      ST_STEP: begin
        // halt has priority; a byte arriving alongside it is dropped
        if (halt_detected) begin
          state_next = ST_DONE;
        end else if (rx_valid) begin
          if (rx_data == CMD_NEXT)      state_next = ST_STEP_PULSE;
          else if (rx_data == CMD_EXIT) state_next = ST_IDLE;
        end
      end
      ST_STEP_PULSE: begin
        state_next = halt_detected ? ST_DONE : ST_STEP;
      end
      ST_DONE: begin
        if (!tx_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are registered from the next state so each strobe lines up
  // with the cycle the FSM actually spends in the corresponding state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_memory_instruction_enable <= 1'b0;
      instruction_to_write         <= '0;
      address_to_write             <= '0;
      mips_enable                  <= 1'b0;
      pc_enable                    <= 1'b0;
      tx_start                     <= 1'b0;
      tx_data                      <= '0;
    end else begin
      wr_memory_instruction_enable <= (state_next == ST_WRITE);
      mips_enable <= (state_next == ST_RUN) || (state_next == ST_STEP_PULSE);
      pc_enable   <= (state_next == ST_RUN) || (state_next == ST_STEP_PULSE);
      tx_start    <= send_ack;
      if (send_ack) tx_data <= ACK_DONE;
      if (asm_ready) instruction_to_write <= INSTRUCTION_LENGTH'(asm_word);
      if (asm_clear) begin
        address_to_write <= '0;
      end else if ((state == ST_WRITE) && (state_next == ST_LOAD)) begin
        address_to_write <= address_to_write + WORD_BYTES;
      end
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequencing controller for the instruction fetch stage and its instruction memory.
- Receives a byte stream from the UART receiver and packs it into 32-bit words.
- Writes those words into instruction memory while the pipeline is stopped.
- Then drives `mips_enable` and `pc_enable` to run the pipeline continuously or one cycle per step command.
- Reports completion back through the UART transmitter.

It sits between the UART pair and the fetch stage, and is the only driver of the fetch stage's enable and write ports.

## Interface
Parameters:
- `INSTRUCTION_LENGTH`, 32, instruction word width.
- `PC_LENGTH`, 32, byte address width.
- `MEM_WORDS`, 64, instruction memory depth in words.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `halt_detected`  in  1  pipeline has retired the HALT instruction.
- `tx_busy`  in  1  UART transmitter is busy.
- `tx_data`  out  8  byte to send.
- `tx_start`  out  1  one-cycle send request.
- `wr_memory_instruction_enable`  out  1  instruction memory write strobe.
- `instruction_to_write`  out  `INSTRUCTION_LENGTH`  write data.
- `address_to_write`  out  `PC_LENGTH`  byte write address.
- `mips_enable`  out  1  pipeline enable.
- `pc_enable`  out  1  PC update enable.

## Operation
Command bytes, accepted only in IDLE:
- `0x4C` 'L' → LOAD.
- `0x43` 'C' → RUN.
- `0x53` 'S` → STEP.
- Any other byte is ignored.

States:
- IDLE: all strobes low.
- LOAD: every `rx_valid` byte is data, MSB first. A byte counter counts 0–3. The 4th byte moves to WRITE with the word latched.
  - `address_to_write` is cleared to 0 on entry to LOAD.
- WRITE (1 cycle):
  - `wr_memory_instruction_enable`=1, with the assembled word and current address.
  - Exits to IDLE if the word is HALT (`0xFC000000`), or if address = `(MEM_WORDS-1)*4` (memory full). Otherwise returns to LOAD with address += 4.
  - `rx_valid` during WRITE is ignored.
- RUN: `mips_enable`=`pc_enable`=1 every cycle until `halt_detected` → DONE.
- STEP: enables low. Byte `0x4E` 'N' → STEP_PULSE. Byte `0x45` 'E' → IDLE. Other bytes ignored. `halt_detected` → DONE.
- STEP_PULSE (1 cycle): `mips_enable`=`pc_enable`=1, then back to STEP. If `halt_detected` is seen in this cycle → DONE.
- DONE: waits for `tx_busy`=0, then issues `tx_start`=1 for one cycle with `tx_data`=`0x44` 'D', then → IDLE.

Invariant: `wr_memory_instruction_enable` and `mips_enable` are never high in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0; state = IDLE, byte counter = 0, address = 0.
- Reset mid-operation: returns immediately to the reset values. A partial word is discarded and the next LOAD restarts at address 0.
- Write latency: the 4th data byte's `rx_valid` in cycle n gives the write strobe in cycle n+1.
- Run start: 'C' strobe in cycle n gives `mips_enable`=1 from cycle n+1.
- Run stop: `halt_detected` in cycle n gives `mips_enable`=0 from cycle n+1 (exactly one extra enabled cycle is not permitted beyond n).
- Step: 'N' in cycle n gives exactly one enabled cycle, at n+1.
- Simultaneous `rx_valid` and `halt_detected` in STEP: halt wins and the byte is dropped.
- The address increment wraps at `PC_LENGTH` width; in practice it is bounded by the memory-full exit.

## Structure
- Shared package `mips_pkg` holds:
  - state encoding (IDLE, LOAD, WRITE, RUN, STEP, STEP_PULSE, DONE);
  - command byte constants `CMD_LOAD`, `CMD_CONT`, `CMD_STEP`, `CMD_NEXT`, `CMD_EXIT`, `ACK_DONE`;
  - `HALT_INSTRUCTION` = `0xFC000000`;
  - `INSTRUCTION_LENGTH` and `PC_LENGTH`.
- One sub-module, `word_assembler`:
  - 32-bit byte shift register plus a 2-bit counter;
  - `clear` input and a `word_ready` pulse.
- The FSM stays in `program_loader`.

## Test plan
- Reset, then 'L' followed by bytes 01 02 03 04 → one write of `0x01020304` at address 0, then state LOAD with address 4.
- Load three words ending in FC 00 00 00 → writes at 0, 4, 8 with the last word `0xFC000000`, return to IDLE, and a later 'C' gives `mips_enable`=1 one cycle after the strobe.
- In RUN, assert `halt_detected` in cycle n → `mips_enable`=0 at n+1; then `tx_start` pulses once with `0x44` after `tx_busy` falls (hold `tx_busy` high for 5 cycles first).
- 'S' then 'N' three times → exactly three single-cycle `pc_enable` pulses; 'E' → IDLE with no further pulses.
- Load 64 non-HALT words → last write at address 252, then automatic return to IDLE; the 65th word's bytes are ignored as commands.
- Assert reset after 2 bytes of a word, then 'L' and 4 bytes AA BB CC DD → the write is `0xAABBCCDD` at address 0.
